gpu_fill_engine: RTL and testbench
==================================

Name: gpu_fill_engine

Overview:
- Command-driven rectangle fill and buffer-swap sequencer upstream of the GPU framebuffer.
- Accepts register writes from the CPU bus interface and expands each fill command into a stream of single-pixel framebuffer writes in raster order.
- Issues buffer-swap requests in order behind pending writes, so the CPU no longer writes every pixel itself.
- Output port feeds the framebuffer's write/swap inputs directly.

Parameters:
- FB_WIDTH, 64, framebuffer width in pixels
- FB_HEIGHT, 48, framebuffer height in pixels
- ADDR_W, 12, framebuffer address width (must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT)

Ports:
- CLK  in  1  system/pixel-domain clock, all logic rising-edge
- RESET_N  in  1  asynchronous active-low reset
- REG_WE  in  1  single-cycle register write strobe (already synchronised to CLK)
- REG_ADDR  in  3  register select
- REG_DATA  in  8  register write data
- BUSY  out  1  high while a command is executing
- ERR  out  1  sticky: CMD written while BUSY; cleared by CMD write of 0x80
- FB_READY  in  1  framebuffer can accept a write/swap this cycle
- FB_WE  out  1  pixel write strobe
- FB_ADDR  out  ADDR_W  pixel address = y*FB_WIDTH + x
- FB_DATA  out  3  pixel colour {B,G,R}
- FB_SWAP  out  1  one-cycle buffer-swap request

Behaviour:
- Reset values: BUSY=0, ERR=0, FB_WE=0, FB_SWAP=0, FB_ADDR=0, FB_DATA=0, all registers 0, state IDLE. Reset mid-command abandons it immediately; no further strobes are issued.
- Registers (write-only, REG_WE && REG_ADDR): 0=X, 1=Y, 2=W, 3=H, 4=COLOR[2:0], 5=CMD, 6-7 ignored.
- X/Y/W/H/COLOR writes are accepted in any state but sampled only at command start.
- CMD codes:
  - 0x01 FILL rect.
  - 0x02 CLEAR: fill 0,0,FB_WIDTH,FB_HEIGHT with COLOR.
  - 0x40 SWAP.
  - 0x80 clear ERR.
  - Any other code: no-op.
- CMD write while BUSY (0x80 excepted): sets ERR; the command is dropped unless the queue option is enabled.
- States: IDLE, FILL, SWAP.
- IDLE to FILL on FILL/CLEAR. IDLE to SWAP on SWAP. BUSY rises the cycle after the CMD strobe.
- Clipping:
  - x_end = min(X+W, FB_WIDTH) and y_end = min(Y+H, FB_HEIGHT), computed 9-bit, no wrap.
  - If W=0, H=0, X>=FB_WIDTH or Y>=FB_HEIGHT, the command completes with zero writes: BUSY is high for exactly 1 cycle, then IDLE.
- FILL:
  - Registered outputs; first FB_WE is asserted the cycle after the CMD strobe.
  - x is the inner loop, y the outer loop.
  - A pixel is consumed on a cycle with FB_WE && FB_READY.
  - When FB_READY=0, FB_WE/FB_ADDR/FB_DATA hold stable.
  - The last pixel is (x_end-1, y_end-1). After its accept: FB_WE=0, BUSY=0, IDLE next cycle.
  - Throughput: one pixel per cycle while FB_READY=1.
- SWAP:
  - FB_SWAP is asserted and held until FB_READY=1. It is consumed that cycle.
  - The following cycle: FB_SWAP=0, BUSY=0, IDLE.
  - FB_SWAP and FB_WE are never high together.
- Address arithmetic is exact (no overflow for legal params). FB_DATA = COLOR latched at start.

Optional Feature:
- GPU_FILL_CMD_QUEUE_EN
- Defined: one-entry command queue. It captures CMD together with a snapshot of X/Y/W/H/COLOR when CMD is written while BUSY and the queue is empty. ERR is set only if the queue is already full. The queued command starts the cycle after the current command's final accept, with no IDLE gap cycle and BUSY staying high.
- Undefined: behaviour as above; no queue logic is synthesised.

Test Plan:
- Reset, then X=2,Y=3,W=3,H=2,COLOR=5,CMD=0x01 with FB_READY=1 -> 6 writes at addresses 194,195,196,258,259,260, FB_DATA=5, one per cycle; BUSY low after the 6th.
- CMD=0x02, COLOR=0 -> 3072 writes, addresses 0..3071 in order; BUSY high for 3072 cycles.
- X=62,Y=47,W=10,H=10 FILL -> clipped to 2 writes at 3070,3071. X=64 -> zero writes, BUSY pulses 1 cycle.
- Fill 2x1 with FB_READY toggled 1,0,0,1 -> FB_ADDR held during stalls; exactly 2 accepted writes. Then CMD=0x40 with FB_READY=0 for 3 cycles -> FB_SWAP held 4 cycles, single accept, no FB_WE overlap.
- CMD=0x01 written during a busy fill -> ERR=1, no extra writes (queue option off). CMD=0x80 -> ERR=0. With the queue option on: second fill runs back-to-back and ERR stays 0 until a third CMD.
- Assert RESET_N low mid-CLEAR at pixel 100 -> FB_WE=0 and BUSY=0 asynchronously. After release, no writes occur until a new CMD.

Source files
------------

// File: rtl/gpu_fill_engine.sv
// gpu_fill_engine: register-driven rectangle fill and buffer-swap sequencer feeding the framebuffer.
// Define GPU_FILL_CMD_QUEUE_EN to add a one-entry command queue that accepts a command while busy.
module gpu_fill_engine #(
  parameter int FB_WIDTH  = 64,
  parameter int FB_HEIGHT = 48,
  parameter int ADDR_W    = 12
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              REG_WE,
  input  logic [2:0]        REG_ADDR,
  input  logic [7:0]        REG_DATA,
  output logic              BUSY,
  output logic              ERR,
  input  logic              FB_READY,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [2:0]        FB_DATA,
  output logic              FB_SWAP
);
  localparam logic [1:0] S_IDLE = 2'd0, S_FILL = 2'd1, S_SWAP = 2'd2;
  localparam logic [7:0] C_FILL = 8'h01, C_CLEAR = 8'h02, C_SWAP = 8'h40, C_ERRCLR = 8'h80;
  localparam logic [8:0] WD = 9'(FB_WIDTH), HT = 9'(FB_HEIGHT);

  logic [1:0]        state_q, state_d;
  logic [7:0]        x_q, y_q, w_q, h_q;
  logic [2:0]        color_q;
  logic [8:0]        cx_q, cx_d, cy_q, cy_d, x0_q, x0_d, xe_q, xe_d, ye_q, ye_d;
  logic              fb_we_q, fb_we_d, fb_swap_q, fb_swap_d, err_q, err_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [2:0]        fb_data_q, fb_data_d;

  logic       cmd_we, cmd_act, busy, row_end, last, done, err_set, st_go;
  logic [7:0] st_cmd, st_x, st_y, st_w, st_h;
  logic [2:0] st_col;
  logic       st_fill, st_clear, st_empty;
  logic [8:0] sx0, sy0, sxe_raw, sye_raw, nx, ny;

  function automatic logic [ADDR_W-1:0] pix(input logic [8:0] px, input logic [8:0] py);
    return ADDR_W'(32'(py) * 32'(FB_WIDTH) + 32'(px));
  endfunction

  assign cmd_we  = REG_WE && REG_ADDR == 3'd5;
  assign cmd_act = cmd_we && REG_DATA != C_ERRCLR;
  assign busy    = state_q != S_IDLE;
  assign row_end = cx_q == xe_q - 9'd1;
  assign last    = row_end && cy_q == ye_q - 9'd1;
  // An empty fill sits in FILL for one cycle with FB_WE low and completes there.
  assign done    = state_q == S_SWAP ? FB_READY
                 : state_q == S_FILL && (!fb_we_q || (FB_READY && last));

`ifdef GPU_FILL_CMD_QUEUE_EN
  logic       qv_q, q_push, q_pop;
  logic [7:0] qcmd_q, qx_q, qy_q, qw_q, qh_q;
  logic [2:0] qcol_q;
  // A command arriving on the completing cycle with an empty queue starts directly.
  assign q_pop   = done && qv_q;
  assign q_push  = busy && cmd_act && (qv_q ? done : !done);
  assign err_set = busy && cmd_act && qv_q && !done;
  assign st_go   = q_pop || (cmd_act && (!busy || done));
  assign st_cmd  = q_pop ? qcmd_q : REG_DATA;
  assign st_x    = q_pop ? qx_q : x_q;
  assign st_y    = q_pop ? qy_q : y_q;
  assign st_w    = q_pop ? qw_q : w_q;
  assign st_h    = q_pop ? qh_q : h_q;
  assign st_col  = q_pop ? qcol_q : color_q;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      qv_q   <= 1'b0;
      qcmd_q <= '0;
      qx_q   <= '0;
      qy_q   <= '0;
      qw_q   <= '0;
      qh_q   <= '0;
      qcol_q <= '0;
    end else begin
      qv_q <= q_push ? 1'b1 : q_pop ? 1'b0 : qv_q;
      if (q_push) begin
        qcmd_q <= REG_DATA;
        qx_q   <= x_q;
        qy_q   <= y_q;
        qw_q   <= w_q;
        qh_q   <= h_q;
        qcol_q <= color_q;
      end
    end
  end
`else
  assign err_set = busy && cmd_act;
  assign st_go   = cmd_act && !busy;
  assign st_cmd  = REG_DATA;
  assign st_x    = x_q;
  assign st_y    = y_q;
  assign st_w    = w_q;
  assign st_h    = h_q;
  assign st_col  = color_q;
`endif

  assign st_fill  = st_cmd == C_FILL;
  assign st_clear = st_cmd == C_CLEAR;
  assign sx0      = st_clear ? 9'd0 : {1'b0, st_x};
  assign sy0      = st_clear ? 9'd0 : {1'b0, st_y};
  assign sxe_raw  = st_clear ? WD : {1'b0, st_x} + {1'b0, st_w};
  assign sye_raw  = st_clear ? HT : {1'b0, st_y} + {1'b0, st_h};
  assign st_empty = st_fill && (st_w == 8'd0 || st_h == 8'd0 || sx0 >= WD || sy0 >= HT);
  assign nx       = row_end ? x0_q : cx_q + 9'd1;
  assign ny       = row_end ? cy_q + 9'd1 : cy_q;

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    x0_d      = x0_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    fb_we_d   = fb_we_q;
    fb_swap_d = fb_swap_q;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (state_q == S_FILL && fb_we_q && FB_READY && !last) begin
      cx_d      = nx;
      cy_d      = ny;
      fb_addr_d = pix(nx, ny);
    end
    if (done) begin
      state_d   = S_IDLE;
      fb_we_d   = 1'b0;
      fb_swap_d = 1'b0;
    end
    if (st_go && (st_fill || st_clear)) begin
      state_d   = S_FILL;
      cx_d      = sx0;
      cy_d      = sy0;
      x0_d      = sx0;
      xe_d      = sxe_raw > WD ? WD : sxe_raw;
      ye_d      = sye_raw > HT ? HT : sye_raw;
      fb_we_d   = !st_empty;
      fb_addr_d = pix(sx0, sy0);
      fb_data_d = st_col;
    end else if (st_go && st_cmd == C_SWAP) begin
      state_d   = S_SWAP;
      fb_swap_d = 1'b1;
    end
    err_d = cmd_we && REG_DATA == C_ERRCLR ? 1'b0 : err_q | err_set;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      state_q   <= S_IDLE;
      cx_q      <= '0;
      cy_q      <= '0;
      x0_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      fb_we_q   <= 1'b0;
      fb_swap_q <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (REG_WE && REG_ADDR == 3'd0) x_q <= REG_DATA;
      if (REG_WE && REG_ADDR == 3'd1) y_q <= REG_DATA;
      if (REG_WE && REG_ADDR == 3'd2) w_q <= REG_DATA;
      if (REG_WE && REG_ADDR == 3'd3) h_q <= REG_DATA;
      if (REG_WE && REG_ADDR == 3'd4) color_q <= REG_DATA[2:0];
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      x0_q      <= x0_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      fb_we_q   <= fb_we_d;
      fb_swap_q <= fb_swap_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      err_q     <= err_d;
    end
  end

  assign BUSY    = busy;
  assign ERR     = err_q;
  assign FB_WE   = fb_we_q;
  assign FB_SWAP = fb_swap_q;
  assign FB_ADDR = fb_addr_q;
  assign FB_DATA = fb_data_q;
endmodule

// File: tb/tb_gpu_fill_engine.sv
// tb_gpu_fill_engine: randomized fill/swap stimulus checked against a raster-loop reference model.
module tb_gpu_fill_engine;
  localparam int FW = 64, FH = 48, LIM = 10000;
`ifdef GPU_FILL_CMD_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic        CLK = 1'b0, RESET_N = 1'b0, REG_WE = 1'b0, FB_READY = 1'b1;
  logic [2:0]  REG_ADDR = '0;
  logic [7:0]  REG_DATA = '0;
  logic        BUSY, ERR, FB_WE, FB_SWAP;
  logic [11:0] FB_ADDR;
  logic [2:0]  FB_DATA;

  int nchk = 0, nerr = 0, stall_bad = 0, swap_bad = 0, ovl_bad = 0, swaps = 0;
  int got_a[$], got_d[$], exp_a[$], exp_d[$];
  logic        pw = 1'b0, ps = 1'b0, pr = 1'b0;
  logic [11:0] pa = '0;
  logic [2:0]  pd = '0;

  gpu_fill_engine #(.FB_WIDTH(FW), .FB_HEIGHT(FH), .ADDR_W(12)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA),
    .BUSY(BUSY), .ERR(ERR), .FB_READY(FB_READY), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR),
    .FB_DATA(FB_DATA), .FB_SWAP(FB_SWAP)
  );

  always #5 CLK = ~CLK;

  // Observes the framebuffer port just after each falling edge, i.e. the values the next rising edge consumes.
  always @(negedge CLK) begin
    #1;
    if (!RESET_N) begin
      pw = 1'b0;
      ps = 1'b0;
    end else begin
      if (pw && !pr && (!FB_WE || FB_ADDR != pa || FB_DATA != pd)) stall_bad++;
      if (ps && !pr && !FB_SWAP) swap_bad++;
      if (FB_WE && FB_SWAP) ovl_bad++;
      if (FB_WE && FB_READY) begin
        got_a.push_back(int'(FB_ADDR));
        got_d.push_back(int'(FB_DATA));
      end
      if (FB_SWAP && FB_READY) swaps++;
      pw = FB_WE;
      ps = FB_SWAP;
      pr = FB_READY;
      pa = FB_ADDR;
      pd = FB_DATA;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge CLK);
    REG_WE = 1'b1;
    REG_ADDR = a;
    REG_DATA = d;
    @(negedge CLK);
    REG_WE = 1'b0;
  endtask

  task automatic model(input logic [7:0] cmd, input int x, input int y, input int w, input int h, input int col);
    int x0 = cmd == 8'h02 ? 0 : x;
    int y0 = cmd == 8'h02 ? 0 : y;
    int xe = cmd == 8'h02 ? FW : (x + w < FW ? x + w : FW);
    int ye = cmd == 8'h02 ? FH : (y + h < FH ? y + h : FH);
    if (cmd != 8'h01 && cmd != 8'h02) return;
    for (int yy = y0; yy < ye; yy++)
      for (int xx = x0; xx < xe; xx++) begin
        exp_a.push_back(yy * FW + xx);
        exp_d.push_back(col);
      end
  endtask

  task automatic wait_idle(input bit rnd, output int n);
    n = 0;
    while (BUSY && n < LIM) begin
      FB_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      n++;
    end
    FB_READY = 1'b1;
    if (n >= LIM) chk("timeout", 32'(BUSY), 0);
  endtask

  task automatic verify(input string tag, input int base);
    int ba = 0, bd = 0;
    chk({tag, "_n"}, 32'(got_a.size() - base), 32'(exp_a.size()));
    foreach (exp_a[i]) begin
      if (base + i >= got_a.size() || got_a[base + i] != exp_a[i]) ba++;
      if (base + i >= got_a.size() || got_d[base + i] != exp_d[i]) bd++;
    end
    chk({tag, "_addr"}, 32'(ba), 0);
    chk({tag, "_data"}, 32'(bd), 0);
  endtask

  task automatic do_fill(input string tag, input logic [7:0] cmd, input int x, input int y,
                         input int w, input int h, input int col, input bit rnd);
    int base, n;
    wr(3'd0, 8'(x));
    wr(3'd1, 8'(y));
    wr(3'd2, 8'(w));
    wr(3'd3, 8'(h));
    wr(3'd4, 8'(col));
    exp_a.delete();
    exp_d.delete();
    model(cmd, x, y, w, h, col);
    base = got_a.size();
    wr(3'd5, cmd);
    wait_idle(rnd, n);
    verify(tag, base);
    if (!rnd) chk({tag, "_busy"}, 32'(n), 32'(exp_a.size() == 0 ? 1 : exp_a.size()));
  endtask

  initial begin
    int base, n, sh;
    repeat (2) @(negedge CLK);
    chk("reset", {BUSY, ERR, FB_WE, FB_SWAP, FB_ADDR, FB_DATA}, 0);
    RESET_N = 1'b1;
    do_fill("fill", 8'h01, 2, 3, 3, 2, 5, 1'b0);
    do_fill("clear", 8'h02, 2, 3, 3, 2, 0, 1'b0);
    do_fill("clip", 8'h01, 62, 47, 10, 10, 6, 1'b0);
    do_fill("xoff", 8'h01, 64, 0, 4, 4, 2, 1'b0);
    do_fill("wzero", 8'h01, 3, 3, 0, 4, 2, 1'b0);
    wr(3'd0, 8'd5);
    wr(3'd1, 8'd1);
    wr(3'd2, 8'd2);
    wr(3'd3, 8'd1);
    wr(3'd4, 8'd3);
    exp_a.delete();
    exp_d.delete();
    model(8'h01, 5, 1, 2, 1, 3);
    base = got_a.size();
    wr(3'd5, 8'h01);
    for (int i = 0; i < 4; i++) begin
      FB_READY = (i == 0 || i == 3);
      @(negedge CLK);
    end
    FB_READY = 1'b1;
    chk("stall_busy", 32'(BUSY), 0);
    verify("stall", base);
    chk("stall_hold", 32'(stall_bad), 0);
    n = swaps;
    sh = 0;
    wr(3'd5, 8'h40);
    for (int i = 0; i < 6; i++) begin
      FB_READY = i >= 3;
      sh += int'(FB_SWAP);
      @(negedge CLK);
    end
    FB_READY = 1'b1;
    chk("swap_len", 32'(sh), 4);
    chk("swap_cnt", 32'(swaps - n), 1);
    chk("swap_idle", {BUSY, FB_SWAP}, 0);
    chk("swap_ovl", 32'(ovl_bad), 0);
    wr(3'd0, 8'd0);
    wr(3'd1, 8'd10);
    wr(3'd2, 8'd10);
    wr(3'd3, 8'd2);
    wr(3'd4, 8'd3);
    exp_a.delete();
    exp_d.delete();
    model(8'h01, 0, 10, 10, 2, 3);
    base = got_a.size();
    wr(3'd5, 8'h01);
    wr(3'd0, 8'd20);
    wr(3'd1, 8'd20);
    wr(3'd2, 8'd4);
    wr(3'd3, 8'd1);
    wr(3'd4, 8'd6);
    wr(3'd5, 8'h01);
    chk("err_second", 32'(ERR), QEN ? 0 : 1);
    if (QEN) model(8'h01, 20, 20, 4, 1, 6);
    wr(3'd5, 8'h01);
    chk("err_third", 32'(ERR), 1);
    wait_idle(1'b0, n);
    verify("busycmd", base);
    wr(3'd5, 8'h80);
    chk("err_clr", 32'(ERR), 0);
    for (int k = 0; k < 10; k++)
      do_fill($sformatf("rnd%0d", k), 8'h01, int'($urandom_range(0, 70)), int'($urandom_range(0, 52)),
              int'($urandom_range(0, 12)), int'($urandom_range(0, 8)), int'($urandom_range(0, 7)), 1'b1);
    wr(3'd4, 8'd1);
    base = got_a.size();
    wr(3'd5, 8'h02);
    n = 0;
    while (got_a.size() < base + 100 && n < LIM) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_pix", 32'(got_a.size() - base), 100);
    #3 RESET_N = 1'b0;
    #1 chk("rst_async", {BUSY, FB_WE, FB_SWAP, ERR}, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    base = got_a.size();
    repeat (20) @(negedge CLK);
    chk("rst_quiet", 32'(got_a.size() - base), 0);
    chk("rst_busy", 32'(BUSY), 0);
    exp_a.delete();
    exp_d.delete();
    base = got_a.size();
    wr(3'd5, 8'h01);
    wait_idle(1'b0, n);
    chk("rst_regs_busy", 32'(n), 1);
    verify("rst_regs", base);
    chk("mon_ovl", 32'(ovl_bad), 0);
    chk("mon_swap", 32'(swap_bad), 0);
    chk("mon_stall", 32'(stall_bad), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
